mem_arbiter: RTL and testbench

- Shares the single-port word memory between the instruction-fetch unit (IF) and the load/store unit (LS).
- Accepts byte-addressed requests on two req/gnt ports and arbitrates between them, LS first with IF starvation protection.
- Converts the byte address to a word index, checks alignment and range, and sequences the memory's registered read/write.
- Routes read data back to the winning requester. Sits between the core front-end/LSU and the memory block.

---
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between the instruction-fetch
// (IF) and load/store (LS) requesters. LS normally wins arbitration. IF is
// forced through after STARVE_LIMIT consecutive losses. Byte addresses are
// checked and converted to word indices, and read data is routed back to the
// requester that owns the current access.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until it sees its one-cycle *_gnt pulse. The gnt marks acceptance. The access
// then completes with a one-cycle if_rvalid / ls_done pulse two cycles after
// arbitration. If the request was rejected, *_err pulses together with *_gnt
// and no completion pulse follows.
module mem_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      r_state, w_next_state;
    logic [3:0]  r_starve_cnt, w_next_starve_cnt;
    logic        r_owner_ls, w_next_owner_ls;   // owner of the access in flight: 1 = LS, 0 = IF
    logic        r_owner_we, w_next_owner_we;   // in-flight access is a write

    logic        r_if_gnt, w_next_if_gnt;
    logic        r_if_rvalid, w_next_if_rvalid;
    logic        r_if_err, w_next_if_err;
    logic        r_ls_gnt, w_next_ls_gnt;
    logic        r_ls_done, w_next_ls_done;
    logic        r_ls_err, w_next_ls_err;
    logic [31:0] r_mem_addr, w_next_mem_addr;
    logic [31:0] r_mem_data, w_next_mem_data;
    logic        r_mem_read, w_next_mem_read;
    logic        r_mem_write, w_next_mem_write;

    logic [31:0] r_if_rdata_hold;
    logic [31:0] r_ls_rdata_hold;

    logic        w_arb_slot;
    logic        w_any_req;
    logic        w_if_wins;
    logic [31:0] w_sel_addr;
    logic        w_sel_we;
    logic        w_addr_err;
    logic        w_ls_read_resp;

    // Winner selection and address check for the request that would win now
    always_comb begin
        w_arb_slot = (r_state == IDLE) || (r_state == RESP);
        w_any_req  = if_req || ls_req;
        w_if_wins  = if_req && (!ls_req || (r_starve_cnt == 4'(STARVE_LIMIT)));
        w_sel_addr = w_if_wins ? if_addr : ls_addr;
        w_sel_we   = w_if_wins ? 1'b0 : ls_we;
        w_addr_err = (w_sel_addr[1:0] != 2'b00) ||
                     ({2'b00, w_sel_addr[31:2]} >= 32'(DEPTH));
    end

    // Next-state and next-output logic of the access sequencer
    always_comb begin
        w_next_state      = r_state;
        w_next_starve_cnt = r_starve_cnt;
        w_next_owner_ls   = r_owner_ls;
        w_next_owner_we   = r_owner_we;
        w_next_if_gnt     = 1'b0;
        w_next_if_rvalid  = 1'b0;
        w_next_if_err     = 1'b0;
        w_next_ls_gnt     = 1'b0;
        w_next_ls_done    = 1'b0;
        w_next_ls_err     = 1'b0;
        w_next_mem_addr   = r_mem_addr;
        w_next_mem_data   = r_mem_data;
        w_next_mem_read   = 1'b0;
        w_next_mem_write  = 1'b0;

        case (r_state)
            IDLE, RESP: begin
                // Starvation count only moves at arbitration points
                if (!if_req || w_if_wins) begin
                    w_next_starve_cnt = 4'd0;
                end else if (r_starve_cnt != 4'hF) begin
                    w_next_starve_cnt = r_starve_cnt + 4'd1;
                end

                if (w_any_req) begin
                    w_next_owner_ls = !w_if_wins;
                    w_next_owner_we = w_sel_we;
                    w_next_if_gnt   = w_if_wins;
                    w_next_ls_gnt   = !w_if_wins;
                    if (w_addr_err) begin
                        // Rejected: pulse err with gnt, skip the memory cycle
                        w_next_if_err = w_if_wins;
                        w_next_ls_err = !w_if_wins;
                        w_next_state  = RESP;
                    end else begin
                        w_next_mem_addr  = {2'b00, w_sel_addr[31:2]};
                        w_next_mem_data  = w_if_wins ? r_mem_data : ls_wdata;
                        w_next_mem_read  = !w_sel_we;
                        w_next_mem_write = w_sel_we;
                        w_next_state     = ISSUE;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                // Memory samples at this edge; data is back in the next cycle
                w_next_if_rvalid = !r_owner_ls;
                w_next_ls_done   = r_owner_ls;
                w_next_state     = RESP;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, starvation counter and ownership registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
            r_owner_ls   <= 1'b0;
            r_owner_we   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_next_starve_cnt;
            r_owner_ls   <= w_next_owner_ls;
            r_owner_we   <= w_next_owner_we;
        end
    end

    // Registered handshake pulses and memory interface
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_ls_done   <= 1'b0;
            r_ls_err    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_data  <= 32'd0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_if_gnt    <= w_next_if_gnt;
            r_if_rvalid <= w_next_if_rvalid;
            r_if_err    <= w_next_if_err;
            r_ls_gnt    <= w_next_ls_gnt;
            r_ls_done   <= w_next_ls_done;
            r_ls_err    <= w_next_ls_err;
            r_mem_addr  <= w_next_mem_addr;
            r_mem_data  <= w_next_mem_data;
            r_mem_read  <= w_next_mem_read;
            r_mem_write <= w_next_mem_write;
        end
    end

    assign w_ls_read_resp = r_ls_done && !r_owner_we;

    // Capture returned read data so each port keeps its last value afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata_hold <= 32'd0;
            r_ls_rdata_hold <= 32'd0;
        end else begin
            if (r_if_rvalid) begin
                r_if_rdata_hold <= mem_rdata;
            end
            if (w_ls_read_resp) begin
                r_ls_rdata_hold <= mem_rdata;
            end
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_err    = r_if_err;
    assign if_rdata  = r_if_rvalid ? mem_rdata : r_if_rdata_hold;
    assign ls_gnt    = r_ls_gnt;
    assign ls_done   = r_ls_done;
    assign ls_err    = r_ls_err;
    assign ls_rdata  = w_ls_read_resp ? mem_rdata : r_ls_rdata_hold;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// word-array reference of the memory contents and the arbitration rules.
module tb_mem_arbiter;

    localparam int DEPTH  = 1024;
    localparam int STARVE = 4;

    // Clock and reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        ls_gnt, ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic [31:0] mem_addr, mem_data;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    mem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Memory block attached to the arbiter: registered read, write on strobe
    logic [31:0] env_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_write) env_mem[mem_addr[9:0]] <= mem_data;
        if (mem_read)  mem_rdata <= env_mem[mem_addr[9:0]];
    end

    // Reference contents, updated only when a write is expected to commit
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] last_if = 32'd0;
    logic [31:0] last_ls = 32'd0;
    int          cyc = 0;
    int          last_gnt_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    // Driver: one IF read, checked through grant and response
    task automatic do_if(input logic [31:0] addr);
        logic e;
        int   idx;
        logic got;
        e   = addr_bad(addr);
        idx = int'(addr[11:2]);
        got = 1'b0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (if_gnt) got = 1'b1;
        end
        if_req = 1'b0;
        check_b("if_gnt_seen", got, 1'b1);
        if (!got) return;
        last_gnt_cyc = cyc;
        check_b("if_err", if_err, e);
        check_b("if_ls_gnt_low", ls_gnt, 1'b0);
        check_b("if_mem_read", mem_read, !e);
        check_b("if_mem_write", mem_write, 1'b0);
        if (!e) check("if_mem_addr", mem_addr, addr >> 2);
        @(posedge clk); #1;
        check_b("if_rvalid", if_rvalid, !e);
        check_b("if_err_cleared", if_err, 1'b0);
        check_b("if_strobe_cleared", mem_read | mem_write, 1'b0);
        if (!e) begin
            check("if_rdata", if_rdata, ref_mem[idx]);
            last_if = ref_mem[idx];
        end else begin
            check("if_rdata_hold_err", if_rdata, last_if);
        end
        check("ls_rdata_hold", ls_rdata, last_ls);
    endtask

    // Driver: one LS read or write, checked through grant and completion
    task automatic do_ls(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic e;
        int   idx;
        logic got;
        e   = addr_bad(addr);
        idx = int'(addr[11:2]);
        got = 1'b0;
        @(negedge clk);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_addr  = addr;
        ls_wdata = wdata;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (ls_gnt) got = 1'b1;
        end
        ls_req = 1'b0;
        check_b("ls_gnt_seen", got, 1'b1);
        if (!got) return;
        last_gnt_cyc = cyc;
        check_b("ls_err", ls_err, e);
        check_b("ls_if_gnt_low", if_gnt, 1'b0);
        check_b("ls_mem_read", mem_read, !e && !we);
        check_b("ls_mem_write", mem_write, !e && we);
        if (!e) check("ls_mem_addr", mem_addr, addr >> 2);
        if (!e && we) check("ls_mem_data", mem_data, wdata);
        @(posedge clk); #1;
        check_b("ls_done", ls_done, !e);
        check_b("ls_err_cleared", ls_err, 1'b0);
        check_b("ls_strobe_cleared", mem_read | mem_write, 1'b0);
        if (!e && we) ref_mem[idx] = wdata;
        if (!e && !we) begin
            check("ls_rdata", ls_rdata, ref_mem[idx]);
            last_ls = ref_mem[idx];
        end
        if (e) check("ls_mem_unchanged", env_mem[idx], ref_mem[idx]);
        check("if_rdata_hold", if_rdata, last_if);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 1100)) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    // Directed steps followed by a randomized phase and the report
    initial begin
        int g1, g2, k, losses, max_losses;
        logic exp_if;

        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = $urandom;
            env_mem[i] = ref_mem[i];
        end
        ref_mem[4] = 32'hDEADBEEF;
        env_mem[4] = 32'hDEADBEEF;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_b("rst_if_gnt", if_gnt, 1'b0);
        check_b("rst_if_rvalid", if_rvalid, 1'b0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check_b("rst_ls_done", ls_done, 1'b0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check_b("rst_errs", if_err | ls_err | ls_gnt, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check_b("rst_strobes", mem_read | mem_write, 1'b0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // IF read of a preloaded word
        do_if(32'h10);
        check("if_first_data", if_rdata, 32'hDEADBEEF);

        // LS write then read back, back-to-back grants
        do_ls(1'b1, 32'h20, 32'h12345678);
        g1 = last_gnt_cyc;
        do_ls(1'b0, 32'h20, 32'd0);
        g2 = last_gnt_cyc;
        check("wr_rd_value", ls_rdata, 32'h12345678);
        check("grant_spacing", 32'(g2 - g1), 32'd2);

        // Both requesters held high: LS wins except every (STARVE+1)th grant
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
        k = 0; losses = 0; max_losses = 0;
        for (int c = 0; c < 200 && k < 15; c++) begin
            @(posedge clk); #1;
            if (if_rvalid) check("starve_if_rdata", if_rdata, ref_mem[4]);
            if (ls_done)   check("starve_ls_rdata", ls_rdata, ref_mem[8]);
            if (if_gnt || ls_gnt) begin
                exp_if = ((k % (STARVE + 1)) == STARVE);
                check_b("starve_winner", if_gnt, exp_if);
                check_b("starve_single_gnt", if_gnt & ls_gnt, 1'b0);
                if (if_gnt) losses = 0;
                else losses++;
                if (losses > max_losses) max_losses = losses;
                k++;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        check("starve_grant_count", 32'(k), 32'd15);
        check_b("starve_bound", max_losses <= STARVE, 1'b1);
        repeat (3) @(posedge clk);
        last_if = ref_mem[4];
        last_ls = ref_mem[8];

        // Rejected requests
        do_ls(1'b1, 32'h22, 32'hAAAA5555);
        check("misaligned_mem_word8", env_mem[8], ref_mem[8]);
        do_if(32'h1000);

        // Reset in the middle of an LS write
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check_b("rst_mid_gnt", ls_gnt, 1'b1);
        check_b("rst_mid_write", mem_write, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_b("rst_mid_write_drop", mem_write, 1'b0);
        check_b("rst_mid_gnt_drop", ls_gnt, 1'b0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
        ls_req = 1'b0;
        @(posedge clk); #1;
        check_b("rst_mid_write_low", mem_write, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_word16", env_mem[16], ref_mem[16]);
        last_if = 32'd0;
        last_ls = 32'd0;
        do_ls(1'b0, 32'h40, 32'd0);

        // Randomized single-requester traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) do_if(rand_addr());
            else do_ls(1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
